grf_wb: RTL and testbench
=========================

Name: grf_wb

Overview:
- General register file for the single-cycle MIPS datapath.
- Sits directly downstream of the write-back selection stage:
  - write address comes from the register-address select (rt / rd / 31 for jal);
  - write data comes from the write-data select (ALU result / memory data / PC+4).
- Supplies the two read operands to the ALU-source stage and the branch compare.
- Also keeps a saturating count of effective register writes, used for debug and bench checking.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; there are 2**ADDR_W registers.
- CNT_W, 32, width of the write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- WE  input  1  register write enable from control.
- RegAddr_W  input  ADDR_W  write register index (output of the register-address select).
- RegData_W  input  DATA_W  write data (output of the write-data select).
- RegAddr_R1  input  ADDR_W  read port 1 index (instr[25:21], rs).
- RegAddr_R2  input  ADDR_W  read port 2 index (instr[20:16], rt).
- RegOut1  output  DATA_W  read port 1 data.
- RegOut2  output  DATA_W  read port 2 data.
- WriteCount  output  CNT_W  number of effective writes since reset; saturating.

Behaviour:
- Storage:
  - registers 1..2**ADDR_W-1 are DATA_W-bit flops;
  - register 0 is not stored and always reads 0.
- Reset (reset=0):
  - takes effect immediately, without waiting for a clock edge;
  - all stored registers and WriteCount go to 0;
  - RegOut1/RegOut2 therefore read 0 combinationally while reset is held;
  - writes presented while reset is low are discarded.
- Reset release: the first rising edge of clk with reset=1 is the first edge that can write.
- Write (single cycle, no handshake):
  - on a rising edge with reset=1, WE=1 and RegAddr_W!=0, the register at RegAddr_W takes RegData_W;
  - the new value is visible on the read ports from that edge onward.
- Writes to register 0:
  - a write with RegAddr_W=0 is dropped and has no side effect;
  - it is not counted.
- WE=0: no state change; RegAddr_W and RegData_W are don't-care.
- Read (zero latency):
  - RegOutN is a combinational function of RegAddr_RN and the current register state;
  - RegAddr_RN=0 gives 0.
- Both read ports may address the same register and return identical data.
- WriteCount:
  - increments by 1 on each effective write (WE=1, RegAddr_W!=0);
  - holds at all ones and does not wrap.
- Same-cycle read and write to the same index: governed by GRF_BYPASS_EN (below).
- Widths:
  - all indices are unsigned;
  - no sign handling inside the block.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined:
  - when WE=1, RegAddr_W!=0 and RegAddr_RN==RegAddr_W, RegOutN returns RegData_W in the same cycle (write-through);
  - this applies independently to each read port;
  - register 0 is never bypassed;
  - the bypass is suppressed while reset=0.
- Undefined:
  - read ports always return the stored value, i.e. the pre-edge value in that cycle;
  - the new value appears after the edge.

Test Plan:
- Reset: hold reset=0 for 3 cycles with WE=1, RegAddr_W=5, RegData_W=32'hDEADBEEF → RegOut1 (R1=5)=0 and WriteCount=0 throughout. Release, then one edge → reg5=32'hDEADBEEF and WriteCount=1.
- $0 protection: WE=1, RegAddr_W=0, RegData_W=32'h12345678, one edge; R1=0, R2=0 → both outputs 0 and WriteCount unchanged.
- jal-style write: WE=1, RegAddr_W=31, RegData_W=32'h00003008; then R1=31, R2=31 → both read 32'h00003008.
- Same-cycle read/write: reg7=32'h1 is stored; WE=1, RegAddr_W=7, RegData_W=32'h2, R2=7 before the edge:
  - with GRF_BYPASS_EN → RegOut2=32'h2;
  - without → RegOut2=32'h1 before the edge and 32'h2 after.
- Async reset mid-run: write regs 1..31 with value = index, then pull reset low between clock edges → all reads 0 immediately and WriteCount=0 within the same timestep.
- Counter saturation (bench with CNT_W=4): perform 20 effective writes → WriteCount stops at 4'hF; WE=0 cycles leave it unchanged.

Source files
------------

// File: rtl/grf_wb.sv
// General register file for the single-cycle MIPS datapath: two async read ports, one write port, saturating write counter.
// Optional macro GRF_BYPASS_EN: same-cycle write-through from the write port to matching read ports.
module grf_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RegAddr_W,
  input  logic [DATA_W-1:0] RegData_W,
  input  logic [ADDR_W-1:0] RegAddr_R1,
  input  logic [ADDR_W-1:0] RegAddr_R2,
  output logic [DATA_W-1:0] RegOut1,
  output logic [DATA_W-1:0] RegOut2,
  output logic [CNT_W-1:0]  WriteCount
);

  localparam int NREG = 2 ** ADDR_W;

  // Register 0 has no storage; it is hardwired to zero on the read side.
  logic [DATA_W-1:0] regs [1:NREG-1];
  logic [CNT_W-1:0]  count;
  logic              wr_eff;

  assign wr_eff = WE && (RegAddr_W != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff) begin
      regs[RegAddr_W] <= RegData_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_eff && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign WriteCount = count;

  always_comb begin
    RegOut1 = '0;
    RegOut2 = '0;
    if (RegAddr_R1 != '0) RegOut1 = regs[RegAddr_R1];
    if (RegAddr_R2 != '0) RegOut2 = regs[RegAddr_R2];
`ifdef GRF_BYPASS_EN
    // Write-through is gated by reset so reads stay zero while reset is held.
    if (reset && wr_eff && (RegAddr_R1 == RegAddr_W)) RegOut1 = RegData_W;
    if (reset && wr_eff && (RegAddr_R2 == RegAddr_W)) RegOut2 = RegData_W;
`endif
  end

endmodule

// File: tb/tb_grf_wb.sv
// Directed self-checking bench for grf_wb: a 32-bit-counter instance plus a 4-bit-counter instance for saturation.
module tb_grf_wb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [4:0]  addr_r1;
  logic [4:0]  addr_r2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] cnt;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [3:0]  cnt_s;

  int n_cmp;
  int n_bad;

  grf_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .WE         (we),
    .RegAddr_W  (addr_w),
    .RegData_W  (data_w),
    .RegAddr_R1 (addr_r1),
    .RegAddr_R2 (addr_r2),
    .RegOut1    (rd1),
    .RegOut2    (rd2),
    .WriteCount (cnt)
  );

  grf_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .WE         (we),
    .RegAddr_W  (addr_w),
    .RegData_W  (data_w),
    .RegAddr_R1 (addr_r1),
    .RegAddr_R2 (addr_r2),
    .RegOut1    (rd1_s),
    .RegOut2    (rd2_s),
    .WriteCount (cnt_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present a write at the falling edge, let the rising edge take it, then drop WE.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we     = 1'b1;
    addr_w = a;
    data_w = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] exp_same;
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    we      = 1'b1;
    addr_w  = 5'd5;
    data_w  = 32'hDEADBEEF;
    addr_r1 = 5'd5;
    addr_r2 = 5'd0;

    // Writes held during reset are discarded.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_rd1", rd1, 32'h0);
      check_eq("rst_cnt", cnt, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    check_eq("rel_reg5", rd1, 32'hDEADBEEF);
    check_eq("rel_cnt", cnt, 32'd1);

    // Register 0 protection
    @(negedge clk);
    we      = 1'b1;
    addr_w  = 5'd0;
    data_w  = 32'h12345678;
    addr_r1 = 5'd0;
    addr_r2 = 5'd0;
    #1;
    check_eq("r0_pre_rd1", rd1, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_eq("r0_rd1", rd1, 32'h0);
    check_eq("r0_rd2", rd2, 32'h0);
    check_eq("r0_cnt", cnt, 32'd1);

    // jal-style write to $31
    do_write(5'd31, 32'h00003008);
    addr_r1 = 5'd31;
    addr_r2 = 5'd31;
    #1;
    check_eq("jal_rd1", rd1, 32'h00003008);
    check_eq("jal_rd2", rd2, 32'h00003008);
    check_eq("jal_cnt", cnt, 32'd2);
    addr_r1 = 5'd5;
    #1;
    check_eq("keep_reg5", rd1, 32'hDEADBEEF);

    // Same-cycle read and write of $7
    do_write(5'd7, 32'h1);
    @(negedge clk);
    we      = 1'b1;
    addr_w  = 5'd7;
    data_w  = 32'h2;
    addr_r2 = 5'd7;
    #1;
`ifdef GRF_BYPASS_EN
    exp_same = 32'h2;
`else
    exp_same = 32'h1;
`endif
    check_eq("same_pre", rd2, exp_same);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_eq("same_post", rd2, 32'h2);
    check_eq("same_cnt", cnt, 32'd4);

    // Fill $1..$31 with their own index
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i));
    end
    check_eq("fill_cnt", cnt, 32'd35);
    for (int i = 1; i < 32; i += 6) begin
      addr_r1 = 5'(i);
      addr_r2 = 5'(31 - i);
      #1;
      check_eq("fill_rd1", rd1, 32'(i));
      check_eq("fill_rd2", rd2, 32'(31 - i));
    end

    // Asynchronous reset between edges
    @(negedge clk);
    addr_r1 = 5'd9;
    addr_r2 = 5'd31;
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_rd1", rd1, 32'h0);
    check_eq("arst_rd2", rd2, 32'h0);
    check_eq("arst_cnt", cnt, 32'h0);
    check_eq("arst_cnt_s", {28'h0, cnt_s}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Saturation of the 4-bit counter
    for (int i = 0; i < 14; i++) begin
      do_write(5'(1 + (i % 31)), 32'hA000_0000 + 32'(i));
    end
    check_eq("sat_cnt14", {28'h0, cnt_s}, 32'hE);
    do_write(5'd3, 32'h33);
    check_eq("sat_cnt15", {28'h0, cnt_s}, 32'hF);
    for (int i = 0; i < 5; i++) begin
      do_write(5'd4, 32'h44);
    end
    check_eq("sat_hold", {28'h0, cnt_s}, 32'hF);
    check_eq("main_cnt20", cnt, 32'd20);
    do_write(5'd0, 32'hFFFF_FFFF);
    check_eq("sat_r0", {28'h0, cnt_s}, 32'hF);
    idle_cycles(3);
    check_eq("sat_idle", {28'h0, cnt_s}, 32'hF);
    check_eq("main_idle", cnt, 32'd20);
    addr_r1 = 5'd3;
    addr_r2 = 5'd4;
    #1;
    check_eq("sat_rd1", rd1_s, 32'h33);
    check_eq("sat_rd2", rd2_s, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
